alu_share_arbiter: RTL and testbench



---
 rtl/alu_share_arbiter.sv | 164 ++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//
// Lets two requesters share one combinational ALU. Only one operation is in
// flight at a time. Each operation goes through three steps:
// accept (IDLE) -> compute (EXEC) -> return (RESP).
// When both ports ask in the same IDLE cycle, they are served round-robin.
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   reqN_valid / reqN_ready        request handshake for port N (N = 0, 1)
//   reqN_fun / reqN_a / reqN_b     function code and operands for port N
//   rspN_valid / rspN_ready        response handshake for port N
//   rspN_result / rspN_err         result, and illegal-function flag (0 while idle)
//   alu_fun / alu_srcA / alu_srcB  registered operands driven to the shared ALU
//   alu_result                     combinational result from the shared ALU
//   busy                           high whenever an operation is in flight
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int FUN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [FUN_W-1:0] req0_fun,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_err,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [FUN_W-1:0] req1_fun,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_err,

    output logic [FUN_W-1:0] alu_fun,
    output logic [WIDTH-1:0] alu_srcA,
    output logic [WIDTH-1:0] alu_srcB,
    input  logic [WIDTH-1:0] alu_result,

    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic             owner;
    logic [FUN_W-1:0] op_fun;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] result_q;
    logic             err_q;
    logic             grant_any;
    logic             grant_port;
    logic             owner_rsp_ready;

    // Round-robin winner selection.
    // On a tie, the port that was not granted last wins.
    // Otherwise the only requesting port wins.
    // A grant is only offered in IDLE and never while reset is held.
    // This keeps the ready outputs low during reset.
    always_comb begin
        grant_port = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_port = ~last_grant;
        end else if (req1_valid) begin
            grant_port = 1'b1;
        end
        grant_any = rst_n && (state == IDLE) && (req0_valid || req1_valid);
    end

    assign req0_ready = grant_any && !grant_port;
    assign req1_ready = grant_any &&  grant_port;

    // Only the owning port's rsp_ready can retire the pending response.
    assign owner_rsp_ready = owner ? rsp1_ready : rsp0_ready;

    // Next-state logic.
    // EXEC always lasts exactly one cycle, which gives the ALU a full cycle
    // to settle on the registered operands.
    // RESP waits for the owner to consume the result.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any)       state_nxt = EXEC;
            EXEC:                         state_nxt = RESP;
            RESP:    if (owner_rsp_ready) state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // State register.
    // A synchronous reset drops any in-flight transaction.
    // last_grant resets to 1 so that port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_any) begin
                owner      <= grant_port;
                last_grant <= grant_port;
            end
        end
    end

    // Datapath registers.
    // The operands are captured only on a handshake, so the ALU inputs stay
    // quiet between operations.
    // The result and the error flag are captured at the end of EXEC and then
    // held for the whole RESP phase.
    // Legal function codes are 0 to 9 and 13. An illegal code still returns
    // whatever the ALU produced.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_fun   <= '0;
            op_a     <= '0;
            op_b     <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (grant_any) begin
                op_fun <= grant_port ? req1_fun : req0_fun;
                op_a   <= grant_port ? req1_a   : req0_a;
                op_b   <= grant_port ? req1_b   : req0_b;
            end
            if (state == EXEC) begin
                result_q <= alu_result;
                err_q    <= !((op_fun <= FUN_W'(9)) || (op_fun == FUN_W'(13)));
            end
        end
    end

    assign alu_fun  = op_fun;
    assign alu_srcA = op_a;
    assign alu_srcB = op_b;

    // Response data is gated by valid, so an idle port never exposes stale data.
    assign rsp0_valid  = (state == RESP) && !owner;
    assign rsp1_valid  = (state == RESP) &&  owner;
    assign rsp0_result = rsp0_valid ? result_q : '0;
    assign rsp1_result = rsp1_valid ? result_q : '0;
    assign rsp0_err    = rsp0_valid && err_q;
    assign rsp1_err    = rsp1_valid && err_q;

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//
// Testbench for alu_share_arbiter.
// A behavioural ALU stub sits on the shared ALU port.
// A transaction-level reference model predicts, every cycle:
//   - which port gets ready,
//   - when the response appears,
//   - what the response carries.
// Directed sequences cover the main scenarios.
// A randomized phase with random resets follows.
module tb_alu_share_arbiter;

    localparam int WIDTH = 32;
    localparam int FUN_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [FUN_W-1:0] req0_fun, req1_fun;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             rsp0_valid, rsp1_valid;
    logic             rsp0_ready, rsp1_ready;
    logic [WIDTH-1:0] rsp0_result, rsp1_result;
    logic             rsp0_err, rsp1_err;
    logic [FUN_W-1:0] alu_fun;
    logic [WIDTH-1:0] alu_srcA, alu_srcB, alu_result;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    // m_wait counts the cycles until the response shows.
    logic             m_busy;
    int               m_wait;
    logic             m_owner;
    logic             m_last;
    logic [WIDTH-1:0] m_res;
    logic             m_err;
    logic [FUN_W-1:0] m_fun;
    logic [WIDTH-1:0] m_a, m_b;
    logic             m_acc0, m_acc1;
    logic             dut_rdy0, dut_rdy1;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(WIDTH), .FUN_W(FUN_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_fun(req0_fun),
        .req0_a(req0_a), .req0_b(req0_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_fun(req1_fun),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_err(rsp1_err),
        .alu_fun(alu_fun), .alu_srcA(alu_srcA), .alu_srcB(alu_srcB),
        .alu_result(alu_result), .busy(busy)
    );

    // RV-style ALU behaviour used both as the external ALU stub and as the
    // golden result.
    // Unimplemented codes return DEADBEEF.
    function automatic logic [WIDTH-1:0] alu_ref(input logic [FUN_W-1:0] f,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        r = '0;
        case (f)
            4'd0:    r = a + b;
            4'd1:    r = a << b[4:0];
            4'd2:    r[0] = ($signed(a) < $signed(b));
            4'd3:    r[0] = (a < b);
            4'd4:    r = a ^ b;
            4'd5:    r = a >> b[4:0];
            4'd6:    r = a | b;
            4'd7:    r = a & b;
            4'd8:    r = a - b;
            4'd13:   r = $signed(a) >>> b[4:0];
            default: r = 32'hDEADBEEF;
        endcase
        return r;
    endfunction

    assign alu_result = alu_ref(alu_fun, alu_srcA, alu_srcB);

    // Counts one comparison and reports it when observed and expected differ.
    task automatic checkOutput(input string tag, input logic [127:0] got,
                               input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Puts the reference model into its post-reset state.
    task automatic modelReset();
        m_busy  = 1'b0;
        m_wait  = 0;
        m_owner = 1'b0;
        m_last  = 1'b1;
        m_res   = '0;
        m_err   = 1'b0;
        m_fun   = '0;
        m_a     = '0;
        m_b     = '0;
    endtask

    // Runs one clock cycle. It must be entered at a falling edge, after the
    // inputs are set.
    // It first checks all outputs against the model.
    // It then advances the model over the rising edge.
    task automatic runCycle();
        logic e_rdy0, e_rdy1, e_v0, e_v1;
        logic             p;
        logic [FUN_W-1:0] f;
        logic [WIDTH-1:0] a, b;
        #1;
        e_rdy0 = rst_n && !m_busy && req0_valid && (!req1_valid || m_last != 1'b0);
        e_rdy1 = rst_n && !m_busy && req1_valid && (!req0_valid || m_last != 1'b1);
        e_v0   = m_busy && (m_wait == 0) && (m_owner == 1'b0);
        e_v1   = m_busy && (m_wait == 0) && (m_owner == 1'b1);
        dut_rdy0 = req0_ready;
        dut_rdy1 = req1_ready;
        checkOutput("req0_ready", req0_ready, e_rdy0);
        checkOutput("req1_ready", req1_ready, e_rdy1);
        checkOutput("rsp0_valid", rsp0_valid, e_v0);
        checkOutput("rsp1_valid", rsp1_valid, e_v1);
        checkOutput("rsp0_result", rsp0_result, e_v0 ? m_res : '0);
        checkOutput("rsp1_result", rsp1_result, e_v1 ? m_res : '0);
        checkOutput("rsp0_err", rsp0_err, e_v0 && m_err);
        checkOutput("rsp1_err", rsp1_err, e_v1 && m_err);
        checkOutput("busy", busy, m_busy);
        checkOutput("alu_ops", {alu_fun, alu_srcA, alu_srcB}, {m_fun, m_a, m_b});
        m_acc0 = e_rdy0;
        m_acc1 = e_rdy1;
        @(posedge clk);
        if (!rst_n) begin
            modelReset();
        end else if (m_acc0 || m_acc1) begin
            p = m_acc1;
            f = p ? req1_fun : req0_fun;
            a = p ? req1_a   : req0_a;
            b = p ? req1_b   : req0_b;
            m_busy  = 1'b1;
            m_wait  = 1;
            m_owner = p;
            m_last  = p;
            m_fun   = f;
            m_a     = a;
            m_b     = b;
            m_res   = alu_ref(f, a, b);
            m_err   = !((f <= 4'd9) || (f == 4'd13));
        end else if (m_busy && m_wait > 0) begin
            m_wait--;
        end else if (m_busy && (m_owner ? rsp1_ready : rsp0_ready)) begin
            m_busy = 1'b0;
        end
        @(negedge clk);
    endtask

    // Holds reset for one checked cycle, then checks the reset state.
    task automatic doReset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        runCycle();
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_alu_ops", {alu_fun, alu_srcA, alu_srcB}, '0);
        rst_n = 1'b1;
    endtask

    // Waits a bounded number of cycles for the DUT to grant port p.
    task automatic waitGrant(input logic p, input string tag);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            runCycle();
            got = p ? dut_rdy1 : dut_rdy0;
        end
        checkOutput(tag, got, 1'b1);
    endtask

    // Retires whatever is in flight, then checks that the DUT went idle.
    task automatic drain();
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int k = 0; k < 10 && busy; k++) runCycle();
        checkOutput("drain_idle", busy, 1'b0);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    // Runs one operation on port p, with constant expected results.
    // It also checks the ALU drive and the response latency.
    task automatic doOp(input logic p, input logic [FUN_W-1:0] f,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] exp_res, input logic exp_err);
        int k;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        if (p) begin
            req1_valid = 1'b1; req1_fun = f; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_fun = f; req0_a = a; req0_b = b;
        end
        waitGrant(p, "op_grant");
        req0_valid = 1'b0; req1_valid = 1'b0;
        checkOutput("op_alu_ops", {alu_fun, alu_srcA, alu_srcB}, {f, a, b});
        k = 0;
        while (!(p ? rsp1_valid : rsp0_valid) && k < 10) begin
            runCycle();
            k++;
        end
        checkOutput("op_latency", k, 1);
        checkOutput("op_result", p ? rsp1_result : rsp0_result, exp_res);
        checkOutput("op_err", p ? rsp1_err : rsp0_err, exp_err);
        if (p) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        runCycle();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    // Drives random requests.
    // A request that is still waiting for its grant is held unchanged.
    // Each cycle has a small chance of reset.
    task automatic applyStimulus();
        rst_n = ($urandom_range(0, 199) != 0);
        if (!(req0_valid && !m_acc0)) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req0_fun   = 4'($urandom_range(0, 15));
            req0_a     = $urandom;
            req0_b     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 31)) : $urandom;
        end
        if (!(req1_valid && !m_acc1)) begin
            req1_valid = ($urandom_range(0, 2) != 0);
            req1_fun   = 4'($urandom_range(0, 15));
            req1_a     = $urandom;
            req1_b     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 31)) : $urandom;
        end
        rsp0_ready = ($urandom_range(0, 3) != 0);
        rsp1_ready = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        int grants[$];
        int k;
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_fun = '0; req0_a = '0; req0_b = '0;
        req1_fun = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        m_acc0 = 1'b0; m_acc1 = 1'b0;
        repeat (2) @(negedge clk);
        modelReset();
        doReset();

        // Basic add: 5 + 7.
        doOp(1'b0, 4'd0, 32'd5, 32'd7, 32'd12, 1'b0);

        // Tie from reset: the grants alternate, and port 0 goes first.
        doReset();
        req0_fun = 4'd8;  req0_a = 32'd10;        req0_b = 32'd3;
        req1_fun = 4'd13; req1_a = 32'h8000_0000; req1_b = 32'd4;
        req0_valid = 1'b1; req1_valid = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int i = 0; i < 40 && grants.size() < 4; i++) begin
            runCycle();
            if (dut_rdy0) grants.push_back(0);
            else if (dut_rdy1) grants.push_back(1);
            if (rsp0_valid) checkOutput("tie_rsp0", rsp0_result, 32'd7);
            if (rsp1_valid) checkOutput("tie_rsp1", rsp1_result, 32'hF800_0000);
        end
        checkOutput("tie_count", grants.size(), 4);
        foreach (grants[i]) checkOutput($sformatf("tie_grant%0d", i), grants[i], i % 2);
        drain();

        // Backpressure on port 1, while port 0 waits.
        req1_fun = 4'd0; req1_a = 32'd1; req1_b = 32'd2; req1_valid = 1'b1;
        waitGrant(1'b1, "bp_grant1");
        req1_valid = 1'b0;
        req0_fun = 4'd4; req0_a = 32'd6; req0_b = 32'd3; req0_valid = 1'b1;
        k = 0;
        while (!rsp1_valid && k < 10) begin
            runCycle();
            k++;
        end
        checkOutput("bp_rsp1_valid", rsp1_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            runCycle();
            checkOutput("bp_result", rsp1_result, 32'd3);
            checkOutput("bp_busy", busy, 1'b1);
            checkOutput("bp_req0_ready", dut_rdy0, 1'b0);
        end
        rsp1_ready = 1'b1;
        runCycle();
        checkOutput("bp_release_no_grant", dut_rdy0, 1'b0);
        rsp1_ready = 1'b0;
        runCycle();
        checkOutput("bp_req0_grant", dut_rdy0, 1'b1);
        drain();

        // Illegal function code.
        doOp(1'b1, 4'hA, 32'd1, 32'd1, 32'hDEAD_BEEF, 1'b1);

        // Reset while port 0's response is pending.
        req0_fun = 4'd0; req0_a = 32'd100; req0_b = 32'd23; req0_valid = 1'b1;
        waitGrant(1'b0, "rst_grant0");
        req0_valid = 1'b0;
        k = 0;
        while (!rsp0_valid && k < 10) begin
            runCycle();
            k++;
        end
        checkOutput("rst_pre_rsp0_valid", rsp0_valid, 1'b1);
        rst_n = 1'b0;
        runCycle();
        checkOutput("rst_rsp0_valid", rsp0_valid, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        rsp0_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            runCycle();
            checkOutput("rst_no_spurious", rsp0_valid, 1'b0);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        req1_fun = 4'd6; req1_a = 32'hF0; req1_b = 32'h0F;
        runCycle();
        checkOutput("rst_tie_grant0", dut_rdy0, 1'b1);
        req0_valid = 1'b0;
        waitGrant(1'b1, "rst_then_grant1");
        drain();

        // Port 1 alone, back to back.
        doOp(1'b1, 4'd2, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        doOp(1'b1, 4'd3, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);

        // Randomized traffic.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            applyStimulus();
            runCycle();
        end
        rst_n = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Stops a hung run with a report instead of spinning forever.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
